// File: rtl/alarm_manager.sv
// alarm_manager: debounces classifier fault decisions into a latched alarm.
// Counts consecutive qualifying faults, raises alarm_active with a one-cycle
// alarm_irq, clears on software ack or (optionally) after a run of normal
// results, and tracks a saturating alarm episode count plus the class that
// raised the most recent alarm.
module alarm_manager #(
    parameter int unsigned CLEAR_COUNT = 4,
    parameter bit          AUTO_CLEAR  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        result_valid,
    input  logic [1:0]  class_id,
    input  logic [7:0]  confidence,
    input  logic [7:0]  alarm_threshold,
    input  logic [3:0]  fault_count_cfg,
    input  logic        alarm_ack,
    output logic        alarm_active,
    output logic        alarm_irq,
    output logic [1:0]  alarm_class,
    output logic [3:0]  fault_streak,
    output logic [15:0] alarm_count
);

    typedef enum logic [0:0] {
        ST_MONITOR = 1'b0,
        ST_ALARM   = 1'b1
    } state_e;

    // Normal-streak target, narrowed to the streak counter width.
    localparam logic [3:0] CLEAR_CNT = 4'(CLEAR_COUNT);

    // Saturating increment for the 4-bit streak counters.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        logic [3:0] r;
        if (v == 4'hF) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

    // Saturating increment for the 16-bit alarm episode counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    state_e      state_q,         state_d;
    logic        alarm_active_q,  alarm_active_d;
    logic        alarm_irq_q,     alarm_irq_d;
    logic [1:0]  alarm_class_q,   alarm_class_d;
    logic [3:0]  fault_streak_q,  fault_streak_d;
    logic [3:0]  normal_streak_q, normal_streak_d;
    logic [15:0] alarm_count_q,   alarm_count_d;

    logic        is_fault_s;
    logic        qualifies_s;
    logic        qf_s;
    logic        normal_s;
    logic [3:0]  eff_cfg_s;
    logic [3:0]  fault_inc_s;
    logic [3:0]  normal_inc_s;
    logic        raise_s;
    logic        clear_hit_s;

    // Decode the incoming result and precompute streak increments/thresholds.
    always_comb begin
        is_fault_s   = (class_id != 2'd0);
        qualifies_s  = (confidence >= alarm_threshold);
        qf_s         = result_valid & is_fault_s & qualifies_s;
        normal_s     = result_valid & ~is_fault_s;
        if (fault_count_cfg == 4'd0) begin
            eff_cfg_s = 4'd1;
        end else begin
            eff_cfg_s = fault_count_cfg;
        end
        fault_inc_s  = sat_inc4(fault_streak_q);
        normal_inc_s = sat_inc4(normal_streak_q);
        raise_s      = qf_s & (fault_inc_s >= eff_cfg_s);
        clear_hit_s  = (AUTO_CLEAR == 1'b1) & normal_s & (normal_inc_s == CLEAR_CNT);
    end

    // Next-state logic: disable and ack always return to MONITOR.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_MONITOR;
        end else begin
            case (state_q)
                ST_MONITOR: begin
                    if (raise_s) begin
                        state_d = ST_ALARM;
                    end else begin
                        state_d = ST_MONITOR;
                    end
                end
                ST_ALARM: begin
                    if (alarm_ack) begin
                        state_d = ST_MONITOR;
                    end else if (clear_hit_s) begin
                        state_d = ST_MONITOR;
                    end else begin
                        state_d = ST_ALARM;
                    end
                end
                default: begin
                    state_d = ST_MONITOR;
                end
            endcase
        end
    end

    // Output and counter updates for the transition chosen above.
    always_comb begin
        alarm_active_d  = (state_d == ST_ALARM);
        alarm_irq_d     = 1'b0;
        alarm_class_d   = alarm_class_q;
        fault_streak_d  = fault_streak_q;
        normal_streak_d = normal_streak_q;
        alarm_count_d   = alarm_count_q;
        if (!enable) begin
            // Count and class survive a disable; streaks start clean.
            fault_streak_d  = 4'd0;
            normal_streak_d = 4'd0;
        end else begin
            case (state_q)
                ST_MONITOR: begin
                    if (raise_s) begin
                        alarm_irq_d     = 1'b1;
                        alarm_class_d   = class_id;
                        alarm_count_d   = sat_inc16(alarm_count_q);
                        fault_streak_d  = 4'd0;
                        normal_streak_d = 4'd0;
                    end else if (qf_s) begin
                        fault_streak_d  = fault_inc_s;
                    end else if (normal_s) begin
                        fault_streak_d  = 4'd0;
                    end else begin
                        fault_streak_d  = fault_streak_q;
                    end
                end
                ST_ALARM: begin
                    if (alarm_ack) begin
                        // Ack discards any result presented in the same cycle.
                        fault_streak_d  = 4'd0;
                        normal_streak_d = 4'd0;
                    end else if (qf_s) begin
                        normal_streak_d = 4'd0;
                    end else if (clear_hit_s) begin
                        normal_streak_d = 4'd0;
                    end else if (normal_s) begin
                        normal_streak_d = normal_inc_s;
                    end else begin
                        normal_streak_d = normal_streak_q;
                    end
                end
                default: begin
                    fault_streak_d  = 4'd0;
                    normal_streak_d = 4'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_MONITOR;
            alarm_active_q  <= 1'b0;
            alarm_irq_q     <= 1'b0;
            alarm_class_q   <= 2'd0;
            fault_streak_q  <= 4'd0;
            normal_streak_q <= 4'd0;
            alarm_count_q   <= 16'd0;
        end else begin
            state_q         <= state_d;
            alarm_active_q  <= alarm_active_d;
            alarm_irq_q     <= alarm_irq_d;
            alarm_class_q   <= alarm_class_d;
            fault_streak_q  <= fault_streak_d;
            normal_streak_q <= normal_streak_d;
            alarm_count_q   <= alarm_count_d;
        end
    end

    assign alarm_active = alarm_active_q;
    assign alarm_irq    = alarm_irq_q;
    assign alarm_class  = alarm_class_q;
    assign fault_streak = fault_streak_q;
    assign alarm_count  = alarm_count_q;

endmodule
